// File: rtl/rx_frame_ring_buffer.sv
// Circular RX buffer: deframer writes at tail, consumer reads any stored address; reading the head frees it.
// Optional almost_full output is compiled in with `define RX_RING_ALMOST_FULL_EN.
module rx_frame_ring_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int AF_THRESH = 2**ADDR_W - 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] head_ptr,
  output logic [ADDR_W-1:0] tail_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf
`ifdef RX_RING_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, wr_ready_q, ovf_q, ovf_d;
  logic              rd_valid_q, rd_err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] off;
  logic              in_win, wr_acc, release_w;

  // Offset from head wraps naturally in ADDR_W bits; in-window iff it lands below count.
  always_comb begin
    off       = rd_addr - head_q;
    in_win    = ({1'b0, off} < count_q);
    wr_acc    = wr_valid && !full_q;
    release_w = rd_req && in_win && (rd_addr == head_q);
    head_d    = release_w ? head_q + 1'b1 : head_q;
    tail_d    = wr_acc ? tail_q + 1'b1 : tail_q;
    count_d   = count_q;
    case ({wr_acc, release_w})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (wr_valid && full_q) ovf_d = 1'b1;
    else if (clr_ovf)       ovf_d = 1'b0;
  end

  // Storage is never reset; reads see pre-write contents.
  always_ff @(posedge clock) begin
    if (!reset && wr_acc) mem[tail_q] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wr_ready_q <= 1'b1;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      full_q     <= (count_d == (ADDR_W+1)'(DEPTH));
      empty_q    <= (count_d == '0);
      wr_ready_q <= (count_d != (ADDR_W+1)'(DEPTH));
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_req;
      rd_err_q   <= rd_req && !in_win;
      if (rd_req) rd_data_q <= in_win ? mem[rd_addr] : '0;
    end
  end

`ifdef RX_RING_ALMOST_FULL_EN
  logic af_q;
  always_ff @(posedge clock) begin
    if (reset) af_q <= 1'b0;
    else       af_q <= (int'(count_d) >= AF_THRESH);
  end
  assign almost_full = af_q;
`endif

  assign wr_ready = wr_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign head_ptr = head_q;
  assign tail_ptr = tail_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;

endmodule
